// File: rtl/spi_rx_slave.sv
// SPI receive endpoint: synchronizes the SPI pins into clk, shifts one DATA_WIDTH-bit word per
// chip-select frame MSB first, and presents it on a valid/ready interface.
module spi_rx_slave #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              spi_cs_l,
  input  logic                              spi_sclk,
  input  logic                              spi_data,
  output logic [DATA_WIDTH-1:0]             rx_data,
  output logic                              rx_valid,
  input  logic                              rx_ready,
  output logic                              overrun,
  output logic                              frame_err,
  output logic                              busy,
  output logic [$clog2(DATA_WIDTH+1)-1:0]   bit_count
);

  localparam int unsigned CntW = $clog2(DATA_WIDTH + 1);
  localparam logic [CntW-1:0] DwCnt = CntW'(DATA_WIDTH);

  typedef enum logic [1:0] {StWaitCs, StIdle, StShift, StDone} state_e;

  logic [SYNC_STAGES-1:0] cs_sync_q, sclk_sync_q, data_sync_q;
  logic                   sclk_prev_q;
  logic                   cs_s, sclk_s, data_s, sclk_rise;

  state_e                 state_q, state_d;
  logic [DATA_WIDTH-1:0]  shift_q, shift_d;
  logic [DATA_WIDTH-1:0]  rx_data_q, rx_data_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic                   extra_q, extra_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   overrun_q, overrun_d;
  logic                   ferr_q, ferr_d;
  logic                   complete;

  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign data_s    = data_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;

  // Reset values (cs=0, sclk=1) keep a frame from starting until CS is seen high.
  always_ff @(posedge clk) begin
    if (reset) begin
      cs_sync_q   <= '0;
      sclk_sync_q <= '1;
      data_sync_q <= '0;
      sclk_prev_q <= 1'b1;
    end else begin
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_l};
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
      data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], spi_data};
      sclk_prev_q <= sclk_s;
    end
  end

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    extra_d    = extra_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q & ~rx_ready;
    overrun_d  = 1'b0;
    ferr_d     = 1'b0;
    complete   = 1'b0;
    unique case (state_q)
      StWaitCs: begin
        if (cs_s) state_d = StIdle;
      end
      StIdle: begin
        cnt_d   = '0;
        extra_d = 1'b0;
        if (!cs_s) begin
          shift_d = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        if (sclk_rise) begin
          shift_d = {shift_q[DATA_WIDTH-2:0], data_s};
          cnt_d   = cnt_q + 1'b1;
          if (cnt_d == DwCnt) begin
            complete  = 1'b1;
            rx_data_d = shift_d;
            state_d   = StDone;
          end
        end
        // The CS check sees the count after any edge taken this cycle.
        if (cs_s) begin
          ferr_d  = (cnt_d != '0) && (cnt_d != DwCnt);
          cnt_d   = '0;
          state_d = StIdle;
        end
      end
      StDone: begin
        if (sclk_rise) extra_d = 1'b1;
        if (cs_s) begin
          ferr_d  = extra_d;
          extra_d = 1'b0;
          cnt_d   = '0;
          state_d = StIdle;
        end
      end
      default: state_d = StWaitCs;
    endcase
    if (complete) begin
      rx_valid_d = 1'b1;
      overrun_d  = rx_valid_q & ~rx_ready;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StWaitCs;
      shift_q    <= '0;
      rx_data_q  <= '0;
      cnt_q      <= '0;
      extra_q    <= 1'b0;
      rx_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      rx_data_q  <= rx_data_d;
      cnt_q      <= cnt_d;
      extra_q    <= extra_d;
      rx_valid_q <= rx_valid_d;
      overrun_q  <= overrun_d;
      ferr_q     <= ferr_d;
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign overrun   = overrun_q;
  assign frame_err = ferr_q;
  assign busy      = (state_q == StShift) || (state_q == StDone);
  assign bit_count = cnt_q;

endmodule
